// File: rtl/rv32_lsu_pkg.sv
// rv32_lsu_pkg: funct3 encodings, LSU state type and byte-lane helper functions
package rv32_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] o);
        return f3[1:0] == 2'b00 ? 4'b0001 << o :
               f3[1:0] == 2'b01 ? 4'b0011 << {o[1], 1'b0} : 4'b1111;
    endfunction

    function automatic logic [31:0] store_rep(input logic [2:0] f3, input logic [31:0] wd);
        return f3[1:0] == 2'b00 ? {4{wd[7:0]}} :
               f3[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] o,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{o, 3'b000} +: 8];
        h = o[1] ? rd[31:16] : rd[15:0];
        return f3[1:0] == 2'b00 ? {{24{~f3[2] & b[7]}}, b} :
               f3[1:0] == 2'b01 ? {{16{~f3[2] & h[15]}}, h} : rd;
    endfunction

endpackage

// File: rtl/rv32_lsu_if.sv
// rv32_lsu_if: req/ack data-bus between the load/store unit and data memory
interface rv32_lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
                    input  bus_ack, bus_rdata);
    modport slave  (input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
                    output bus_ack, bus_rdata);
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store lane replication, byte enables, load byte/half select and extension
module lsu_lane_align
    import rv32_lsu_pkg::*;
(
    input  logic [2:0]  f3,
    input  logic [1:0]  o,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);

    assign be    = lane_be(f3, o);
    assign wdata = store_rep(f3, wd);
    assign rdata = load_ext(f3, o, rd);

endmodule

// File: rtl/rv32_load_store_unit.sv
// rv32_load_store_unit: M-stage load/store unit; optional MISALIGN_TRAP_EN faults misaligned accesses
module rv32_load_store_unit
    import rv32_lsu_pkg::*;
#(
    parameter int word_width     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            funct3M,
    input  logic [word_width-1:0] ALUResultM,
    input  logic [word_width-1:0] WriteDataM,
    output logic [word_width-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  fault_o,
    rv32_lsu_if.master            bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    lsu_state_t  state;
    logic [CW-1:0] cnt;
    logic [2:0]  f3_q;
    logic [1:0]  o_q;
    logic        ld_q;
    logic        mem_op;
    logic        mis;
    logic [2:0]  f3_s;
    logic [1:0]  o_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] rdata_s;

    assign mem_op = MemReadM | MemWriteM;
    assign StallM = state == BUSY || (state == IDLE && mem_op);
    // the aligner sees the live access in IDLE and the latched one while the bus returns data
    assign f3_s   = state == IDLE ? funct3M : f3_q;
    assign o_s    = state == IDLE ? ALUResultM[1:0] : o_q;

`ifdef MISALIGN_TRAP_EN
    assign mis = (funct3M[1:0] == 2'b01 && ALUResultM[0]) ||
                 (funct3M[1:0] == 2'b10 && ALUResultM[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    lsu_lane_align u_align (
        .f3    (f3_s),
        .o     (o_s),
        .wd    (WriteDataM),
        .rd    (bus.bus_rdata),
        .be    (be_s),
        .wdata (wdata_s),
        .rdata (rdata_s)
    );

    // access FSM with timeout counter and registered bus/result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            f3_q          <= '0;
            o_q           <= '0;
            ld_q          <= 1'b0;
            ReadDataM     <= '0;
            fault_o       <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fault_o <= 1'b0;
                    if (mem_op) begin
                        f3_q          <= funct3M;
                        o_q           <= ALUResultM[1:0];
                        ld_q          <= ~MemWriteM;
                        cnt           <= '0;
                        bus.bus_we    <= MemWriteM;
                        bus.bus_addr  <= {ALUResultM[word_width-1:2], 2'b00};
                        bus.bus_wdata <= wdata_s;
                        bus.bus_be    <= be_s;
                        if (mis) begin
                            state     <= DONE;
                            fault_o   <= 1'b1;
                            ReadDataM <= '0;
                        end else begin
                            state       <= BUSY;
                            bus.bus_req <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        ReadDataM   <= ld_q ? rdata_s : '0;
                        state       <= DONE;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        bus.bus_req <= 1'b0;
                        fault_o     <= 1'b1;
                        ReadDataM   <= '0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    fault_o <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_load_store_unit.sv
// tb_rv32_load_store_unit: randomized accesses against a byte-lane arithmetic reference model
module tb_rv32_load_store_unit;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM;
    logic        StallM, fault_o;
    int          vectors = 0;
    int          errors = 0;

    rv32_lsu_if bus();

    rv32_load_store_unit #(.word_width(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .fault_o    (fault_o),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // one full access, called at a negedge while the unit is idle; dly = BUSY cycle index of the ack
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat, input int dly);
        longint n, base, v, mask;
        logic [3:0]  be;
        logic [31:0] wdat, ext;
        bit mis, to;
        int busy;
        n    = longint'(1) << f3[1:0];
        base = longint'(a[1:0]) - (longint'(a[1:0]) % n);
        be   = 4'(((longint'(1) << n) - 1) << base);
        wdat = n == 1 ? wd[7:0] * 32'h01010101 : n == 2 ? wd[15:0] * 32'h00010001 : wd;
        mask = (longint'(1) << (8 * n)) - 1;
        v    = (longint'(rdat) >> (8 * base)) & mask;
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        ext  = 32'(v);
`ifdef MISALIGN_TRAP_EN
        mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 0);
`else
        mis = 0;
`endif
        to   = dly >= TO;
        busy = to ? TO : dly + 1;
        MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = a; WriteDataM = wd;
        #1;
        check("stall_idle", StallM, rd | wr);
        @(negedge clk);
        if (!(rd | wr)) begin
            check("nomem_req", bus.bus_req, 0);
            check("nomem_stall", StallM, 0);
            return;
        end
        if (!mis) begin
            for (int k = 0; k < busy; k++) begin
                check("busy_req", bus.bus_req, 1);
                check("busy_stall", StallM, 1);
                check("busy_we", bus.bus_we, wr);
                check("busy_addr", bus.bus_addr, {a[31:2], 2'b00});
                check("busy_be", bus.bus_be, be);
                if (wr) check("busy_wdata", bus.bus_wdata, wdat);
                if (k == dly) begin bus.bus_ack = 1; bus.bus_rdata = rdat; end
                @(negedge clk);
                bus.bus_ack = 0;
                bus.bus_rdata = $urandom;
            end
        end
        check("done_stall", StallM, 0);
        check("done_req", bus.bus_req, 0);
        check("done_fault", fault_o, to | mis);
        check("done_rdata", ReadDataM, (rd && !wr && !to && !mis) ? ext : 32'h0);
        MemReadM = 0; MemWriteM = 0;
        @(negedge clk);
        check("after_fault", fault_o, 0);
        check("after_stall", StallM, 0);
        check("after_req", bus.bus_req, 0);
    endtask

    initial begin
        logic [2:0] f3;
        logic rd, wr;
        int dly;
        rst_n = 0; MemReadM = 0; MemWriteM = 0; funct3M = 0; ALUResultM = 0; WriteDataM = 0;
        bus.bus_ack = 0; bus.bus_rdata = 0;
        repeat (2) @(negedge clk);
        check("rst_rdata", ReadDataM, 0);
        check("rst_stall", StallM, 0);
        check("rst_req", bus.bus_req, 0);
        check("rst_fault", fault_o, 0);
        check("rst_be", bus.bus_be, 0);
        check("rst_addr", bus.bus_addr, 0);
        rst_n = 1;
        @(negedge clk);
        bus.bus_ack = 1; bus.bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus.bus_ack = 0;
        check("stray_req", bus.bus_req, 0);
        check("stray_rdata", ReadDataM, 0);
        check("stray_stall", StallM, 0);

        access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1);
        access(0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0);
        access(1, 0, 3'b000, 32'h101, 0, 32'h000080FF, 0);
        access(1, 0, 3'b100, 32'h101, 0, 32'h000080FF, 0);
        access(1, 0, 3'b101, 32'h102, 0, 32'hBEEF1234, 2);
        access(1, 0, 3'b010, 32'h104, 0, 32'h12345678, TO);
        access(1, 0, 3'b010, 32'h104, 0, 32'h12345678, TO - 1);
        access(1, 1, 3'b010, 32'h108, 32'h55AA55AA, 32'hCAFEF00D, 0);
        access(0, 0, 3'b000, 32'h10C, 0, 0, 0);
        access(1, 0, 3'b010, 32'h102, 0, 32'h11223344, 0);

        MemReadM = 1; funct3M = 3'b010; ALUResultM = 32'h200;
        repeat (3) @(negedge clk);
        rst_n = 0; MemReadM = 0;
        @(negedge clk);
        check("rstbusy_req", bus.bus_req, 0);
        check("rstbusy_stall", StallM, 0);
        check("rstbusy_rdata", ReadDataM, 0);
        rst_n = 1;
        bus.bus_ack = 1; bus.bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus.bus_ack = 0;
        check("late_req", bus.bus_req, 0);
        check("late_rdata", ReadDataM, 0);
        check("late_fault", fault_o, 0);
        check("late_stall", StallM, 0);

        for (int i = 0; i < 300; i++) begin
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 9) != 0);
            f3 = wr && !rd ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
            if (!(wr && !rd) && f3 == 3'd3) f3 = 3'd4;
            if (f3 == 3'd4 && $urandom_range(0, 1) == 1) f3 = 3'd5;
            if (wr && f3[2]) f3 = {1'b0, f3[1:0]};
            dly = $urandom_range(0, 9) == 0 ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 3);
            access(rd, wr, f3, $urandom, $urandom, $urandom, dly);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
